// File: rtl/clk_div_monitor.sv
// Cycle-exact period/high-time monitor for a divided clock sampled in its source domain.
// Tracks lock against EXP_DIVIDE and flags loss of lock and stalls.
module clk_div_monitor #(
  parameter int EXP_DIVIDE = 4,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 2,
  parameter int TIMEOUT    = 20
) (
  input  logic       I,
  input  logic       w_CLR,
  input  logic       DIV_I,
  output logic       LOCKED,
  output logic       ERR,
  output logic       STALL,
  output logic [4:0] PERIOD,
  output logic [3:0] HIGH_CNT,
  output logic [7:0] EDGE_CNT
);

  typedef enum logic [1:0] {ACQ, SEARCH, LCK, STL} st_t;

  st_t        st, st_nxt;
  logic       r_div_q;
  logic [4:0] r_cnt;
  logic [3:0] r_hi;
  logic [3:0] good_cnt, good_nxt, bad_cnt, bad_nxt;
  logic       rise, good, tmo_hit, err_nxt, meas_upd;

  assign rise = DIV_I & ~r_div_q;
  assign good = (r_cnt == 5'(EXP_DIVIDE));
  // Compare against the post-increment count so STALL asserts as r_cnt reaches TIMEOUT.
  assign tmo_hit = ~rise && (r_cnt >= 5'(TIMEOUT - 1));

  always_ff @(posedge I or posedge w_CLR) begin
    if (w_CLR) begin
      r_div_q <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
    end else begin
      r_div_q <= DIV_I;
      if (rise) begin
        r_cnt <= 5'd1;
        r_hi  <= 4'd1;
      end else begin
        if (r_cnt != '1) r_cnt <= r_cnt + 5'd1;
        if (DIV_I && r_hi != '1) r_hi <= r_hi + 4'd1;
      end
    end
  end

  always_ff @(posedge I or posedge w_CLR) begin
    if (w_CLR) begin
      st       <= ACQ;
      good_cnt <= '0;
      bad_cnt  <= '0;
      LOCKED   <= 1'b0;
      STALL    <= 1'b0;
      ERR      <= 1'b0;
      PERIOD   <= '0;
      HIGH_CNT <= '0;
      EDGE_CNT <= '0;
    end else begin
      st       <= st_nxt;
      good_cnt <= good_nxt;
      bad_cnt  <= bad_nxt;
      LOCKED   <= (st_nxt == LCK);
      STALL    <= (st_nxt == STL);
      ERR      <= err_nxt;
      if (meas_upd) begin
        PERIOD   <= r_cnt;
        HIGH_CNT <= r_hi;
      end
      if (rise && EDGE_CNT != '1) EDGE_CNT <= EDGE_CNT + 8'd1;
    end
  end

  always_comb begin
    st_nxt   = st;
    good_nxt = good_cnt;
    bad_nxt  = bad_cnt;
    if (rise) begin
      case (st)
        // The period ending at this edge started from reset or a stall and is meaningless.
        ACQ, STL: begin
          st_nxt   = SEARCH;
          good_nxt = '0;
        end
        SEARCH: begin
          if (good) begin
            good_nxt = good_cnt + 4'd1;
            if (good_cnt + 4'd1 == 4'(LOCK_COUNT)) begin
              st_nxt  = LCK;
              bad_nxt = '0;
            end
          end else begin
            good_nxt = '0;
          end
        end
        LCK: begin
          if (good) begin
            bad_nxt = '0;
          end else begin
            bad_nxt = bad_cnt + 4'd1;
            if (bad_cnt + 4'd1 == 4'(ERR_LIMIT)) begin
              st_nxt   = SEARCH;
              good_nxt = '0;
            end
          end
        end
        default: st_nxt = ACQ;
      endcase
    end else if (tmo_hit && st != STL) begin
      st_nxt = STL;
    end
  end

  always_comb begin
    err_nxt  = (st == LCK) && (st_nxt != LCK);
    meas_upd = rise && (st == SEARCH || st == LCK);
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: two instances (ratio 4 / timeout 20, ratio 3 / timeout 31)
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_clk_div_monitor;

  localparam int EXPD[2] = '{4, 3};
  localparam int TMO[2]  = '{20, 31};
  localparam int LOCKN   = 4;
  localparam int ERRL    = 2;
  localparam int P_ACQ = 0, P_SRCH = 1, P_LOCK = 2, P_STALL = 3;

  logic       I = 1'b0;
  logic       w_CLR = 1'b1;
  logic [1:0] dv = '0;
  wire  [1:0] lk, er, stl;
  wire  [4:0] per0, per1;
  wire  [3:0] hc0, hc1;
  wire  [7:0] ec0, ec1;

  clk_div_monitor #(.EXP_DIVIDE(4), .LOCK_COUNT(LOCKN), .ERR_LIMIT(ERRL), .TIMEOUT(20)) u_d0 (
    .I(I), .w_CLR(w_CLR), .DIV_I(dv[0]), .LOCKED(lk[0]), .ERR(er[0]), .STALL(stl[0]),
    .PERIOD(per0), .HIGH_CNT(hc0), .EDGE_CNT(ec0));
  clk_div_monitor #(.EXP_DIVIDE(3), .LOCK_COUNT(LOCKN), .ERR_LIMIT(ERRL), .TIMEOUT(31)) u_d1 (
    .I(I), .w_CLR(w_CLR), .DIV_I(dv[1]), .LOCKED(lk[1]), .ERR(er[1]), .STALL(stl[1]),
    .PERIOD(per1), .HIGH_CNT(hc1), .EDGE_CNT(ec1));

  always #5 I = ~I;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int m_el[2], m_hi[2], m_ph[2], m_good[2], m_bad[2], m_edges[2], m_per[2], m_hc[2];
  bit m_prev[2], m_err[2], prev_stl[2];
  int edge_cyc[2], stall_cyc[2], errcnt[2];

  task automatic chk(string nm, logic [31:0] act, int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic m_reset(int i);
    m_el[i] = 0; m_hi[i] = 0; m_ph[i] = P_ACQ; m_good[i] = 0; m_bad[i] = 0;
    m_edges[i] = 0; m_per[i] = 0; m_hc[i] = 0; m_prev[i] = 0; m_err[i] = 0;
  endtask

  // Unbounded elapsed/high-sample counters; saturation applied only where reported.
  task automatic m_step(int i, bit d);
    bit r;
    r = d && !m_prev[i];
    m_prev[i] = d;
    m_err[i] = 0;
    if (r) begin
      edge_cyc[i] = cyc;
      if (m_edges[i] < 255) m_edges[i]++;
      if (m_ph[i] == P_SRCH || m_ph[i] == P_LOCK) begin
        m_per[i] = (m_el[i] > 31) ? 31 : m_el[i];
        m_hc[i]  = (m_hi[i] > 15) ? 15 : m_hi[i];
      end
      case (m_ph[i])
        P_SRCH: begin
          if (m_per[i] == EXPD[i]) begin
            m_good[i]++;
            if (m_good[i] == LOCKN) begin m_ph[i] = P_LOCK; m_bad[i] = 0; end
          end else m_good[i] = 0;
        end
        P_LOCK: begin
          if (m_per[i] == EXPD[i]) m_bad[i] = 0;
          else begin
            m_bad[i]++;
            if (m_bad[i] == ERRL) begin m_err[i] = 1; m_ph[i] = P_SRCH; m_good[i] = 0; end
          end
        end
        default: begin m_ph[i] = P_SRCH; m_good[i] = 0; end
      endcase
      m_el[i] = 1;
      m_hi[i] = 1;
    end else begin
      m_el[i]++;
      if (d) m_hi[i]++;
      if (m_el[i] >= TMO[i] && m_ph[i] != P_STALL) begin
        if (m_ph[i] == P_LOCK) m_err[i] = 1;
        m_ph[i] = P_STALL;
      end
    end
  endtask

  always @(posedge I) begin
    bit d[2];
    logic [4:0] p[2];
    logic [3:0] h[2];
    logic [7:0] e[2];
    d[0] = dv[0]; d[1] = dv[1];
    #1;
    cyc++;
    p[0] = per0; p[1] = per1; h[0] = hc0; h[1] = hc1; e[0] = ec0; e[1] = ec1;
    for (int i = 0; i < 2; i++) begin
      if (w_CLR) m_reset(i); else m_step(i, d[i]);
      chk($sformatf("d%0d.LOCKED", i), 32'(lk[i]), int'(m_ph[i] == P_LOCK));
      chk($sformatf("d%0d.STALL", i), 32'(stl[i]), int'(m_ph[i] == P_STALL));
      chk($sformatf("d%0d.ERR", i), 32'(er[i]), int'(m_err[i]));
      chk($sformatf("d%0d.PERIOD", i), 32'(p[i]), m_per[i]);
      chk($sformatf("d%0d.HIGH_CNT", i), 32'(h[i]), m_hc[i]);
      chk($sformatf("d%0d.EDGE_CNT", i), 32'(e[i]), m_edges[i]);
      if (er[i] === 1'b1) errcnt[i]++;
      if (stl[i] === 1'b1 && !prev_stl[i]) stall_cyc[i] = cyc;
      prev_stl[i] = (stl[i] === 1'b1);
    end
  end

  task automatic drv(int i, bit v, int n);
    repeat (n) begin @(negedge I); dv[i] = v; end
  endtask

  task automatic prd(int i, int h, int l);
    drv(i, 1'b1, h);
    drv(i, 1'b0, l);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, ".LOCKED"}, 32'(lk[0]), 0);
    chk({tag, ".ERR"}, 32'(er[0]), 0);
    chk({tag, ".STALL"}, 32'(stl[0]), 0);
    chk({tag, ".PERIOD"}, 32'(per0), 0);
    chk({tag, ".HIGH_CNT"}, 32'(hc0), 0);
    chk({tag, ".EDGE_CNT"}, 32'(ec0), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not end, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 chk_zero("rst");
    repeat (3) @(negedge I);
    w_CLR = 1'b0;

    // clean lock, 2 high / 2 low
    repeat (4) prd(0, 2, 2);
    chk("lock.pre5", 32'(lk[0]), 0);
    prd(0, 2, 2);
    chk("lock.at5", 32'(lk[0]), 1);
    chk("lock.PERIOD", 32'(per0), 4);
    chk("lock.HIGH_CNT", 32'(hc0), 2);
    chk("lock.EDGE_CNT", 32'(ec0), 5);

    // periods 5, 4, 5, 5
    prd(0, 2, 3);
    prd(0, 2, 2);
    chk("loss.single_bad_keeps", 32'(lk[0]), 1);
    prd(0, 2, 3);
    prd(0, 2, 3);
    prd(0, 2, 2);
    chk("loss.dropped", 32'(lk[0]), 0);
    chk("loss.err_pulses", 32'(errcnt[0]), 1);
    repeat (4) prd(0, 2, 2);
    chk("relock", 32'(lk[0]), 1);

    // stall while locked
    drv(0, 1'b0, 25);
    chk("stall.STALL", 32'(stl[0]), 1);
    chk("stall.latency", 32'(stall_cyc[0] - edge_cyc[0]), 19);
    chk("stall.err_pulses", 32'(errcnt[0]), 2);
    prd(0, 2, 2);
    chk("resume.PERIOD_kept", 32'(per0), 4);
    chk("resume.STALL", 32'(stl[0]), 0);
    repeat (3) prd(0, 2, 2);
    chk("resume.pre_lock", 32'(lk[0]), 0);
    prd(0, 2, 2);
    chk("resume.lock", 32'(lk[0]), 1);

    // async reset mid-period while locked
    @(negedge I); dv[0] = 1'b1;
    @(negedge I);
    #1 w_CLR = 1'b1;
    #1 chk_zero("arst");
    dv[0] = 1'b0;
    @(negedge I); w_CLR = 1'b0;
    repeat (4) prd(0, 2, 2);
    chk("arst.pre_lock", 32'(lk[0]), 0);
    chk("arst.EDGE_CNT4", 32'(ec0), 4);
    prd(0, 2, 2);
    chk("arst.lock", 32'(lk[0]), 1);
    chk("arst.EDGE_CNT5", 32'(ec0), 5);

    repeat (300) prd(0, 2, 2);
    chk("sat.EDGE_CNT", 32'(ec0), 255);

    // odd ratio, 1 high / 2 low
    repeat (4) prd(1, 1, 2);
    chk("odd.pre_lock", 32'(lk[1]), 0);
    prd(1, 1, 2);
    chk("odd.lock", 32'(lk[1]), 1);
    chk("odd.PERIOD", 32'(per1), 3);
    chk("odd.HIGH_CNT", 32'(hc1), 1);

    // hold high well past timeout
    drv(1, 1'b1, 41);
    chk("hold.STALL", 32'(stl[1]), 1);
    chk("hold.r_cnt_sat", 32'(u_d1.r_cnt), 31);
    chk("hold.HIGH_CNT", 32'(hc1), 1);
    chk("hold.err_pulses", 32'(errcnt[1]), 1);
    drv(1, 1'b0, 2);
    prd(1, 1, 2);
    chk("hold.resume_HIGH_CNT", 32'(hc1), 1);
    chk("hold.resume_PERIOD", 32'(per1), 3);
    chk("hold.resume_STALL", 32'(stl[1]), 0);

    repeat (3) @(negedge I);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Measures the period of a divided clock against the fast clock it was derived from, and reports lock, mismatch and stall status. It sits beside a clock-divider buffer instance and consumes that divider's output as a plain data input, sampled in the source clock domain. It gives simulation benches and on-chip health logic a cycle-exact check that the divider is producing the configured ratio.

## Interface
- `EXP_DIVIDE`, default 4: expected divide ratio, legal range 2..8. 1 is not supported because a divide-by-1 output cannot be sampled by its own source clock.
- `LOCK_COUNT`, default 4: consecutive correct periods required to assert lock, legal range 1..15.
- `ERR_LIMIT`, default 2: consecutive wrong periods while locked that drop lock, legal range 1..15.
- `TIMEOUT`, default 20: cycles without a rising edge before declaring a stall, legal range `2*EXP_DIVIDE`..31.
- `I` input, 1 bit: fast source clock; all logic is on posedge `I`.
- `w_CLR` input, 1 bit: reset w_CLR, asynchronous, active-high.
- `DIV_I` input, 1 bit: divided clock under test, treated as data.
- `LOCKED` output, 1 bit: ratio verified.
- `ERR` output, 1 bit: one-cycle pulse when lock is lost.
- `STALL` output, 1 bit: no rising edge within `TIMEOUT` cycles.
- `PERIOD` output, 5 bits: last measured period in `I` cycles.
- `HIGH_CNT` output, 4 bits: `I` cycles `DIV_I` was high in the last period, saturating at 15.
- `EDGE_CNT` output, 8 bits: number of rising edges detected, saturating at 255.

## Operation
- `r_div_q` holds `DIV_I` sampled at each posedge `I`. A rising edge is `DIV_I & ~r_div_q`, evaluated at the same posedge.
- `r_cnt` (5 bits):
  - On an edge, load 1.
  - Otherwise increment, saturating at 31.
  - At an edge, the measured period is the pre-load value of `r_cnt`.
- `r_hi` (4 bits):
  - On an edge, load 1.
  - Otherwise increment while `DIV_I` = 1, saturating at 15.
  - At an edge, `HIGH_CNT` takes the pre-load value of `r_hi`.
- A period is good when `measured == EXP_DIVIDE`.
- State machine `st`:
  - **ACQ**: entered after reset and after a stall. The first edge only starts measurement; it updates nothing except `EDGE_CNT`. It then goes to SEARCH with `good_cnt`=0.
  - **SEARCH**:
    - Good period: `good_cnt`+1. When the count reaches `LOCK_COUNT`, go to LOCKED with `bad_cnt`=0.
    - Bad period: `good_cnt`=0.
  - **LOCKED**:
    - Good period: `bad_cnt`=0.
    - Bad period: `bad_cnt`+1. When the count reaches `ERR_LIMIT`, pulse `ERR`, go to SEARCH with `good_cnt`=0.
  - **STALL**:
    - Entered from any other state when there is no edge and `r_cnt` ≥ `TIMEOUT`.
    - If the state was LOCKED, `ERR` also pulses.
    - The next edge moves to SEARCH. That edge's period is invalid, so treat it as the ACQ first edge: `PERIOD` is not updated and `good_cnt`=0.
- Outputs are registered:
  - `LOCKED` = (st == LOCKED).
  - `STALL` = (st == STALL).
- Simultaneous events:
  - An edge on the same cycle the timeout threshold is reached counts as an edge; there is no stall.
  - `EDGE_CNT` increments on every edge in all states.
- Reset values: `st`=ACQ, `r_div_q`=0, `r_cnt`=0, `r_hi`=0, `good_cnt`/`bad_cnt`=0, and every output 0.
- Reset mid-operation clears all state immediately. The first edge after release is an ACQ edge.

## Timing
- Edge detection latency: `DIV_I` rising before posedge k of `I` (sampled 1 at k, 0 at k-1) updates `PERIOD`, `HIGH_CNT`, `EDGE_CNT` and `st` at posedge k. They are visible after k.
- `LOCKED` rises at the edge that completes the `LOCK_COUNT`-th consecutive good period. With a clean source that is edge number 1 + `LOCK_COUNT` after reset.
- `ERR` is high for exactly one `I` cycle, at the posedge that leaves LOCKED.
- `STALL` rises at the posedge where `r_cnt` reaches `TIMEOUT`, i.e. `TIMEOUT`-1 cycles after the last edge.
- `DIV_I` transitions must be stable at posedge `I`. A divider output changing on posedge `I` is sampled with its pre-edge value (nonblocking semantics).

## Test plan
- **Clean lock.** EXP_DIVIDE=4, LOCK_COUNT=4; drive `DIV_I` 2 high/2 low.
  - Required: `PERIOD`=4 from edge 2 onward; `LOCKED`=1 at edge 5; `HIGH_CNT`=2.
- **Odd ratio.** EXP_DIVIDE=3; drive 1 high/2 low.
  - Required: `PERIOD`=3, `HIGH_CNT`=1; `LOCKED` rises at edge 5.
- **Loss of lock.** While locked (EXP_DIVIDE=4, ERR_LIMIT=2), insert periods of 5 then 4 then 5, 5.
  - Required: the single bad period keeps `LOCKED`=1. The second consecutive bad period pulses `ERR` for 1 cycle and drops `LOCKED` to 0.
- **Stall.** While locked, hold `DIV_I`=0.
  - Required: `STALL`=1 and `ERR` pulses 19 cycles after the last edge (TIMEOUT=20).
  - On resumption, `PERIOD` is unchanged at the first edge, and `LOCKED` returns after 4 more good periods.
- **Async reset.** Assert `w_CLR` mid-period while locked.
  - Required: all outputs read 0 before the next posedge `I`.
  - After release, `EDGE_CNT` counts from 0 and lock needs 5 edges.
- **Saturation.** Run 300 edges.
  - Required: `EDGE_CNT` holds at 255.
  - Hold `DIV_I`=1 for 40 cycles with TIMEOUT=31: `HIGH_CNT` is not updated and `r_cnt` saturates at 31 with no wrap.
